// File: rtl/i2s_frame_sequencer.sv
// Master-mode I2S frame controller.
// Produces the word-select waveform and the per-bit strobes that drive the
// bit-serial adder datapath. All state advances on the falling edge of sck,
// so the datapath can sample the strobes on the following rising edge.
// Every output is decoded from registered state only.
module i2s_frame_sequencer #(
    parameter int WIDTH = 24,   // maximum data bits per channel word
    parameter int SLOT  = 32,   // sck cycles per channel half-frame (>= WIDTH+1)
    parameter int FCW   = 8     // frame counter width
) (
    input  logic                                    sck,
    input  logic                                    reset,
    input  logic                                    en,
    input  logic [4:0]                              word_len,
    output logic                                    ws,
    output logic                                    chan,
    output logic                                    bit_en,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] bit_idx,
    output logic                                    first,
    output logic                                    last,
    output logic                                    busy,
    output logic [FCW-1:0]                          frame_cnt,
    output logic                                    cfg_err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (SLOT > 1) ? $clog2(SLOT) : 1;
    // Common width for comparing the slot counter against the word length.
    localparam int CW = ((SW > 5) ? SW : 5) + 1;

    localparam logic [SW-1:0] SC_LAST = SW'(SLOT - 1);
    localparam logic [4:0]    WL_MAX  = 5'(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mode_t;

    mode_t          mode_reg, mode_next;
    logic [SW-1:0]  sc_reg, sc_next;
    logic           chan_reg, chan_next;
    logic [4:0]     wl_reg, wl_next;
    logic [FCW-1:0] frame_cnt_reg, frame_cnt_next;
    logic           cfg_err_reg, cfg_err_next;

    logic           latch_len;
    logic           len_bad;
    logic           at_slot_end;
    logic           data_slot;
    logic [CW-1:0]  sc_ext;
    logic [CW-1:0]  wl_ext;

    assign len_bad     = (word_len == 5'd0) || (word_len > WL_MAX);
    assign at_slot_end = (mode_reg == RUN) && (sc_reg == SC_LAST);
    assign sc_ext      = CW'(sc_reg);
    assign wl_ext      = CW'(wl_reg);

    // State register: asynchronous reset, updates on the sck falling edge.
    always_ff @(negedge sck or posedge reset) begin
        if (reset) begin
            mode_reg      <= IDLE;
            sc_reg        <= '0;
            chan_reg      <= 1'b1;
            wl_reg        <= WL_MAX;
            frame_cnt_reg <= '0;
            cfg_err_reg   <= 1'b0;
        end else begin
            mode_reg      <= mode_next;
            sc_reg        <= sc_next;
            chan_reg      <= chan_next;
            wl_reg        <= wl_next;
            frame_cnt_reg <= frame_cnt_next;
            cfg_err_reg   <= cfg_err_next;
        end
    end

    // Next-state logic: slot counting, channel toggling, frame end and length latch.
    always_comb begin
        mode_next      = mode_reg;
        sc_next        = sc_reg;
        chan_next      = chan_reg;
        wl_next        = wl_reg;
        frame_cnt_next = frame_cnt_reg;
        cfg_err_next   = cfg_err_reg;
        latch_len      = 1'b0;

        case (mode_reg)
            IDLE: begin
                if (en) begin
                    mode_next = RUN;
                    chan_next = 1'b0;
                    sc_next   = '0;
                    latch_len = 1'b1;
                end
            end
            RUN: begin
                if (at_slot_end) begin
                    sc_next = '0;
                    if (chan_reg) begin
                        // End of the right channel closes the frame; en only
                        // matters here, so a frame is never cut short.
                        frame_cnt_next = frame_cnt_reg + FCW'(1);
                        if (en) begin
                            chan_next = 1'b0;
                            latch_len = 1'b1;
                        end else begin
                            mode_next = IDLE;  // chan stays 1, keeping ws high
                        end
                    end else begin
                        chan_next = 1'b1;
                    end
                end else begin
                    sc_next = sc_reg + SW'(1);
                end
            end
            default: begin
                mode_next = IDLE;
            end
        endcase

        // Word length is captured only on entry to a left-channel slot 0,
        // so it is fixed for the whole frame.
        if (latch_len) begin
            if (len_bad) begin
                wl_next      = WL_MAX;
                cfg_err_next = 1'b1;
            end else begin
                wl_next      = word_len;
                cfg_err_next = 1'b0;
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        // Data bits follow the ws edge by one slot: sc 1..wl.
        data_slot = (mode_reg == RUN) && (sc_ext != '0) && (sc_ext <= wl_ext);
        // ws leads the right channel by one slot; it is already high at the
        // end of the right channel, so the fall into the left channel happens
        // together with sc = 0 and an en drop leaves ws high without a glitch.
        ws        = (mode_reg == IDLE) || chan_reg || at_slot_end;
        chan      = chan_reg;
        bit_en    = data_slot;
        bit_idx   = data_slot ? IW'(sc_reg - SW'(1)) : '0;
        first     = data_slot && (sc_reg == SW'(1));
        last      = data_slot && (sc_ext == wl_ext);
        busy      = (mode_reg == RUN);
        frame_cnt = frame_cnt_reg;
        cfg_err   = cfg_err_reg;
    end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Directed testbench for i2s_frame_sequencer (WIDTH=24, SLOT=32, FCW=8).
// Inputs change and outputs are sampled just after the sck rising edge;
// the design updates on the falling edge.
module tb_i2s_frame_sequencer;

    logic       sck;
    logic       reset;
    logic       en;
    logic [4:0] word_len;
    logic       ws;
    logic       chan;
    logic       bit_en;
    logic [4:0] bit_idx;
    logic       first;
    logic       last;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;
    int fc_exp = 0;

    // Packed observation: {ws, chan, bit_en, bit_idx, first, last, busy, cfg_err, frame_cnt}
    logic [19:0] obs;
    assign obs = {ws, chan, bit_en, bit_idx, first, last, busy, cfg_err, frame_cnt};

    i2s_frame_sequencer #(
        .WIDTH(24),
        .SLOT (32),
        .FCW  (8)
    ) dut (
        .sck      (sck),
        .reset    (reset),
        .en       (en),
        .word_len (word_len),
        .ws       (ws),
        .chan     (chan),
        .bit_en   (bit_en),
        .bit_idx  (bit_idx),
        .first    (first),
        .last     (last),
        .busy     (busy),
        .frame_cnt(frame_cnt),
        .cfg_err  (cfg_err)
    );

    initial sck = 1'b1;
    always #5 sck = ~sck;

    // One sck period: design updates on the falling edge, we resume after the rising edge.
    task automatic step();
        @(negedge sck);
        @(posedge sck);
    endtask

    // Expected outputs at frame slot s (0..63: left 0..31, right 32..63).
    function automatic logic [19:0] exp_vec(input int s, input int wl, input logic cfg, input int fc);
        int         sc;
        logic       c, w, be, f, l;
        logic [4:0] idx;
        c   = (s >= 32);
        sc  = s % 32;
        w   = c | (sc == 31);
        be  = (sc >= 1) && (sc <= wl);
        idx = be ? 5'(sc - 1) : 5'd0;
        f   = be && (sc == 1);
        l   = be && (sc == wl);
        return {w, c, be, idx, f, l, 1'b1, cfg, 8'(fc)};
    endfunction

    // Expected outputs while idle.
    function automatic logic [19:0] idle_vec(input logic cfg, input int fc);
        return {1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, cfg, 8'(fc)};
    endfunction

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; word_len = 5'd24;
        step(); step();
        checks++;
        if (obs !== idle_vec(1'b0, 0)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, idle_vec(1'b0, 0));
        end
        reset = 1'b0;
        step(); step(); step();
        checks++;
        if (obs !== idle_vec(1'b0, 0)) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h", obs, idle_vec(1'b0, 0));
        end
        $display("reset: state=%h", obs);
    endtask

    task automatic test_full_word();
        word_len = 5'd24; en = 1'b1;
        step();
        for (int s = 0; s < 64; s++) begin
            checks++;
            if (obs !== exp_vec(s, 24, 1'b0, fc_exp)) begin
                errors++;
                $display("FAIL full_word slot %0d: got %h expected %h", s, obs, exp_vec(s, 24, 1'b0, fc_exp));
            end
            if (s == 62) en = 1'b0;
            step();
        end
        fc_exp++;
        checks++;
        if (obs !== idle_vec(1'b0, fc_exp)) begin
            errors++;
            $display("FAIL full_word_idle: got %h expected %h", obs, idle_vec(1'b0, fc_exp));
        end
        $display("full_word: wl=24 frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_word_len_one();
        word_len = 5'd1; en = 1'b1;
        step();
        for (int s = 0; s < 64; s++) begin
            checks++;
            if (obs !== exp_vec(s, 1, 1'b0, fc_exp)) begin
                errors++;
                $display("FAIL word_len_one slot %0d: got %h expected %h", s, obs, exp_vec(s, 1, 1'b0, fc_exp));
            end
            if (s == 62) en = 1'b0;
            step();
        end
        fc_exp++;
        checks++;
        if (obs !== idle_vec(1'b0, fc_exp)) begin
            errors++;
            $display("FAIL word_len_one_idle: got %h expected %h", obs, idle_vec(1'b0, fc_exp));
        end
        $display("word_len_one: wl=1 frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_cfg_err();
        int         wl_e [3];
        logic       cfg_e [3];
        logic [4:0] nxt [3];
        wl_e  = '{24, 24, 16};
        cfg_e = '{1'b1, 1'b1, 1'b0};
        nxt   = '{5'd30, 5'd16, 5'd16};
        word_len = 5'd0; en = 1'b1;
        step();
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 64; s++) begin
                checks++;
                if (obs !== exp_vec(s, wl_e[f], cfg_e[f], fc_exp)) begin
                    errors++;
                    $display("FAIL cfg_err frame %0d slot %0d: got %h expected %h",
                             f, s, obs, exp_vec(s, wl_e[f], cfg_e[f], fc_exp));
                end
                if (s == 20) word_len = nxt[f];
                if (f == 2 && s == 62) en = 1'b0;
                step();
            end
            fc_exp++;
            $display("cfg_err: frame %0d wl=%0d cfg_err=%0d", f, wl_e[f], cfg_e[f]);
        end
        checks++;
        if (obs !== idle_vec(1'b0, fc_exp)) begin
            errors++;
            $display("FAIL cfg_err_idle: got %h expected %h", obs, idle_vec(1'b0, fc_exp));
        end
    endtask

    task automatic test_midframe_len();
        int wl_e [2];
        wl_e = '{24, 8};
        word_len = 5'd24; en = 1'b1;
        step();
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 64; s++) begin
                checks++;
                if (obs !== exp_vec(s, wl_e[f], 1'b0, fc_exp)) begin
                    errors++;
                    $display("FAIL midframe_len frame %0d slot %0d: got %h expected %h",
                             f, s, obs, exp_vec(s, wl_e[f], 1'b0, fc_exp));
                end
                if (f == 0 && s == 10) word_len = 5'd8;
                if (f == 1 && s == 62) en = 1'b0;
                step();
            end
            fc_exp++;
            $display("midframe_len: frame %0d wl=%0d", f, wl_e[f]);
        end
        checks++;
        if (obs !== idle_vec(1'b0, fc_exp)) begin
            errors++;
            $display("FAIL midframe_len_idle: got %h expected %h", obs, idle_vec(1'b0, fc_exp));
        end
    endtask

    task automatic test_drop_en();
        word_len = 5'd24; en = 1'b1;
        step();
        for (int s = 0; s < 64; s++) begin
            checks++;
            if (obs !== exp_vec(s, 24, 1'b0, fc_exp)) begin
                errors++;
                $display("FAIL drop_en slot %0d: got %h expected %h", s, obs, exp_vec(s, 24, 1'b0, fc_exp));
            end
            if (s == 5) en = 1'b0;
            step();
        end
        fc_exp++;
        checks++;
        if (obs !== idle_vec(1'b0, fc_exp)) begin
            errors++;
            $display("FAIL drop_en_idle: got %h expected %h", obs, idle_vec(1'b0, fc_exp));
        end
        step(); step();
        checks++;
        if (obs !== idle_vec(1'b0, fc_exp)) begin
            errors++;
            $display("FAIL drop_en_stay_idle: got %h expected %h", obs, idle_vec(1'b0, fc_exp));
        end
        $display("drop_en: frame completed, frame_cnt=%0d busy=%0d", frame_cnt, busy);
    endtask

    task automatic test_async_reset();
        reset = 1'b1; step(); reset = 1'b0;
        fc_exp = 0;
        word_len = 5'd24; en = 1'b1;
        step();
        for (int f = 0; f < 255; f++)
            for (int s = 0; s < 64; s++) step();
        checks++;
        if (obs !== exp_vec(0, 24, 1'b0, 255)) begin
            errors++;
            $display("FAIL count_255: got %h expected %h", obs, exp_vec(0, 24, 1'b0, 255));
        end
        for (int s = 0; s < 44; s++) step();
        checks++;
        if (obs !== exp_vec(44, 24, 1'b0, 255)) begin
            errors++;
            $display("FAIL right_sc12: got %h expected %h", obs, exp_vec(44, 24, 1'b0, 255));
        end
        // Assert reset between clock edges; outputs must clear before any falling edge.
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== idle_vec(1'b0, 0)) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs, idle_vec(1'b0, 0));
        end
        en = 1'b0;
        step();
        reset = 1'b0;
        step();
        checks++;
        if (obs !== idle_vec(1'b0, 0)) begin
            errors++;
            $display("FAIL after_reset: got %h expected %h", obs, idle_vec(1'b0, 0));
        end
        $display("async_reset: mid-frame reset cleared, frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_wrap();
        word_len = 5'd24; en = 1'b1;
        step();
        for (int f = 0; f < 255; f++)
            for (int s = 0; s < 64; s++) step();
        checks++;
        if (obs !== exp_vec(0, 24, 1'b0, 255)) begin
            errors++;
            $display("FAIL wrap_pre: got %h expected %h", obs, exp_vec(0, 24, 1'b0, 255));
        end
        for (int s = 0; s < 64; s++) step();
        checks++;
        if (obs !== exp_vec(0, 24, 1'b0, 0)) begin
            errors++;
            $display("FAIL wrap_zero: got %h expected %h", obs, exp_vec(0, 24, 1'b0, 0));
        end
        $display("wrap: after 256 frames frame_cnt=%0d", frame_cnt);
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        word_len = 5'd24;
        test_reset();
        test_full_word();
        test_word_len_one();
        test_cfg_err();
        test_midframe_len();
        test_drop_en();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
